sdiv_seq: RTL and testbench

//  Multi-cycle signed integer divider. Inverse of the SMULT datapath component.

---
 rtl/sdiv_seq_pkg.sv | 16 +
 rtl/sdiv_seq_if.sv | 26 ++
 rtl/sdiv_seq_div_step.sv | 26 ++
 rtl/sdiv_seq.sv | 147 ++++++++++++++
 tb/tb_sdiv_seq.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdiv_seq_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and
// the default operand width used across the component library.
package sdiv_seq_pkg;

  localparam int DEFAULT_DATAWIDTH = 16;

  // IDLE waits for start, ITER retires one quotient bit per clock,
  // SIGN applies the result signs, ZERO handles a zero divisor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    ZERO = 2'd3
  } state_t;

endpackage

// File: rtl/sdiv_seq_if.sv
// Request/result bundle for sdiv_seq. The requester (master) drives start
// and the operands; the divider (slave) returns status and results.
import sdiv_seq_pkg::*;

interface sdiv_seq_if #(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
);
  logic                 start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] quot;
  logic [DATAWIDTH-1:0] rem;
  logic                 divzero;

  modport master (
    output start, a, b,
    input  busy, done, quot, rem, divzero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, divzero
  );
endinterface

// File: rtl/sdiv_seq_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract the divisor and
// keep the difference only when it did not borrow.
module sdiv_seq_div_step #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] partial_rem,
  input  logic                 next_bit,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] new_rem,
  output logic                 quot_bit
);

  // One extra bit so the borrow of the trial subtract is never lost.
  logic [DATAWIDTH:0] shifted;
  logic [DATAWIDTH:0] trial;

  // Trial subtract; the top bit of the difference is the borrow.
  always_comb begin
    shifted  = {partial_rem, next_bit};
    trial    = shifted - {1'b0, divisor};
    quot_bit = ~trial[DATAWIDTH];
    new_rem  = quot_bit ? trial[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
  end

endmodule

// File: rtl/sdiv_seq.sv
// Multi-cycle signed divider (restoring, one quotient bit per clock).
// Operands are reduced to magnitudes on accept, divided unsigned, and the
// signs are reapplied in a final cycle. Quotient truncates toward zero and
// the remainder takes the sign of the dividend.
import sdiv_seq_pkg::*;

module sdiv_seq #(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input logic        clk,
  input logic        rst,
  sdiv_seq_if.slave  bus
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg, count_next;
  // Dividend magnitude; quotient bits shift in at the LSB as it empties.
  logic [DATAWIDTH-1:0] dvd_reg, dvd_next;
  logic [DATAWIDTH-1:0] dsr_reg, dsr_next;
  logic [DATAWIDTH-1:0] prem_reg, prem_next;
  logic                 sign_q_reg, sign_q_next;
  logic                 sign_r_reg, sign_r_next;
  logic [DATAWIDTH-1:0] quot_reg, quot_next;
  logic [DATAWIDTH-1:0] rem_reg, rem_next;
  logic                 divzero_reg, divzero_next;
  logic                 done_reg, done_next;

  logic [DATAWIDTH-1:0] a_mag;
  logic [DATAWIDTH-1:0] b_mag;
  logic [DATAWIDTH-1:0] step_rem;
  logic                 step_bit;

  // Unsigned magnitudes of the incoming operands; |MIN| fits as unsigned.
  assign a_mag = bus.a[DATAWIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = bus.b[DATAWIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  sdiv_seq_div_step #(
    .DATAWIDTH (DATAWIDTH)
  ) u_step (
    .partial_rem (prem_reg),
    .next_bit    (dvd_reg[DATAWIDTH-1]),
    .divisor     (dsr_reg),
    .new_rem     (step_rem),
    .quot_bit    (step_bit)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath updates for each phase of the division.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    dvd_next     = dvd_reg;
    dsr_next     = dsr_reg;
    prem_next    = prem_reg;
    sign_q_next  = sign_q_reg;
    sign_r_next  = sign_r_reg;
    quot_next    = quot_reg;
    rem_next     = rem_reg;
    divzero_next = divzero_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          dvd_next     = a_mag;
          dsr_next     = b_mag;
          prem_next    = '0;
          sign_q_next  = bus.a[DATAWIDTH-1] ^ bus.b[DATAWIDTH-1];
          sign_r_next  = bus.a[DATAWIDTH-1];
          divzero_next = 1'b0;
          count_next   = CW'(DATAWIDTH);
          state_next   = (bus.b == '0) ? ZERO : ITER;
        end
      end
      ITER: begin
        dvd_next   = {dvd_reg[DATAWIDTH-2:0], step_bit};
        prem_next  = step_rem;
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        // MIN / -1 wraps back to MIN here, with no flag.
        quot_next  = sign_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
        rem_next   = sign_r_reg ? (~prem_reg + 1'b1) : prem_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      ZERO: begin
        // Dividend was never shifted, so re-signing it recovers a as given.
        quot_next    = '0;
        rem_next     = sign_r_reg ? (~dvd_reg + 1'b1) : dvd_reg;
        divzero_next = 1'b1;
        done_next    = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand, working and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      dvd_reg     <= '0;
      dsr_reg     <= '0;
      prem_reg    <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      divzero_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      count_reg   <= count_next;
      dvd_reg     <= dvd_next;
      dsr_reg     <= dsr_next;
      prem_reg    <= prem_next;
      sign_q_reg  <= sign_q_next;
      sign_r_reg  <= sign_r_next;
      quot_reg    <= quot_next;
      rem_reg     <= rem_next;
      divzero_reg <= divzero_next;
      done_reg    <= done_next;
    end
  end

  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = done_reg;
  assign bus.quot    = quot_reg;
  assign bus.rem     = rem_reg;
  assign bus.divzero = divzero_reg;

endmodule

// File: tb/tb_sdiv_seq.sv
// Self-checking bench for sdiv_seq at DATAWIDTH=8. Stimulus pushes the
// expected result into a queue; a monitor pops and compares on every done.
module tb_sdiv_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_txn = 0;
  res_t exp_q[$];

  sdiv_seq_if #(.DATAWIDTH(W)) bus();

  sdiv_seq #(.DATAWIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero.
  function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib);
    res_t res;
    int   sa, sb, qi, ri;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    if (sb == 0) begin
      res.q  = '0;
      res.r  = ia;
      res.dz = 1'b1;
    end else begin
      qi     = sa / sb;
      ri     = sa % sb;
      res.q  = qi[W-1:0];
      res.r  = ri[W-1:0];
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t got, e;
    if (!rst && bus.done) begin
      got = {bus.quot, bus.rem, bus.divzero};
      n_txn++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done txn %0d: got quot=%0d rem=%0d divzero=%0b, required no done",
                 n_txn, $signed(bus.quot), $signed(bus.rem), bus.divzero);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL result txn %0d: got quot=%0d rem=%0d divzero=%0b, required quot=%0d rem=%0d divzero=%0b",
                   n_txn, $signed(got.q), $signed(got.r), got.dz, $signed(e.q), $signed(e.r), e.dz);
        end else begin
          $display("txn %0d: quot=%0d rem=%0d divzero=%0b ok",
                   n_txn, $signed(got.q), $signed(got.r), got.dz);
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", guard);
    end
  endtask

  // Issue one request; returns on the negedge after it was accepted.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    exp_q.push_back(model(ia, ib));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Issue one request and measure edges to done and cycles with busy high.
  task automatic timed(input logic [W-1:0] ia, input logic [W-1:0] ib, input int exp_lat);
    int lat = -1;
    int bc  = 0;
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    exp_q.push_back(model(ia, ib));
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) bus.start = 1'b0;
      if (j > 0) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      if (bus.busy) bc++;
      if (bus.done) begin
        lat = j;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", bc, exp_lat);
  endtask

  // Hold start high; fresh operands at each done, noise while busy.
  task automatic b2b(input int nops);
    int issued = 0;
    int dones  = 0;
    int gap    = 0;
    int guard  = 0;
    logic [W-1:0] ra, rb;
    @(negedge clk);
    wait_idle();
    ra = W'($urandom);
    do rb = W'($urandom); while (rb == '0);
    bus.start = 1'b1;
    bus.a     = ra;
    bus.b     = rb;
    exp_q.push_back(model(ra, rb));
    issued = 1;
    while (dones < nops && guard < nops * 20) begin
      @(negedge clk);
      guard++;
      gap++;
      if (bus.done) begin
        dones++;
        check("b2b_period", gap, 10);
        gap = 0;
        if (issued < nops) begin
          ra = W'($urandom);
          do rb = W'($urandom); while (rb == '0);
          bus.a = ra;
          bus.b = rb;
          exp_q.push_back(model(ra, rb));
          issued++;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
    end
    bus.start = 1'b0;
    check("b2b_dones", dones, nops);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int guard;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_quot", int'(bus.quot), 0);
    check("rst_rem", int'(bus.rem), 0);
    check("rst_divzero", int'(bus.divzero), 0);
    rst = 1'b0;

    // Basic case with latency, then the sign and overflow corners.
    timed(W'(100), W'(7), 9);
    issue(W'(-100), W'(7));
    issue(W'(100), W'(-7));
    issue(W'(-100), W'(-7));
    issue(W'(-128), W'(-1));
    issue(W'(-128), W'(1));

    // Divide by zero, then a normal op clears divzero.
    timed(W'(55), W'(0), 1);
    timed(W'(9), W'(3), 9);

    b2b(6);

    // Reset in the middle of an iteration (count=4) abandons the op.
    timed(W'(100), W'(7), 9);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(77);
    bus.b     = W'(5);
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      if (j == 0) bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_quot", int'(bus.quot), 0);
    check("arst_rem", int'(bus.rem), 0);
    check("arst_divzero", int'(bus.divzero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    timed(W'(-77), W'(5), 9);

    // Random operands with biased corners (zero, -1, MIN).
    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = '1;
        2: ra = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      issue(ra, rb);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
